// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared pipeline definitions: register numbers, ALU opcodes, control bundle and
// ID/EX next-state actions. Imported by the ID/EX register and its hazard detector.
package id_ex_pipe_reg_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int ALUOP_W = 4;
  localparam logic [3:0] ALUOP_ADD  = 4'd0;
  localparam logic [3:0] ALUOP_SUB  = 4'd1;
  localparam logic [3:0] ALUOP_AND  = 4'd2;
  localparam logic [3:0] ALUOP_OR   = 4'd3;
  localparam logic [3:0] ALUOP_XOR  = 4'd4;
  localparam logic [3:0] ALUOP_NOR  = 4'd5;
  localparam logic [3:0] ALUOP_SLT  = 4'd6;
  localparam logic [3:0] ALUOP_SLTU = 4'd7;
  localparam logic [3:0] ALUOP_SLL  = 4'd8;
  localparam logic [3:0] ALUOP_SRL  = 4'd9;
  localparam logic [3:0] ALUOP_SRA  = 4'd10;
  localparam logic [3:0] ALUOP_LUI  = 4'd11;

  localparam int CTRL_W = 5;

  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
    logic memtoreg;
    logic alusrc;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = ctrl_t'(5'b00000);

  // Ordered by the register's next-state priority (reset is handled in the flop itself)
  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_HOLD   = 2'd2,
    ACT_FLUSH  = 2'd3
  } pipe_act_e;

  // An instruction slot that is not valid must not carry side-effecting controls
  function automatic ctrl_t gate_ctrl(input ctrl_t c, input logic v);
    ctrl_t g;
    if (v) begin
      g = c;
    end else begin
      g = CTRL_BUBBLE;
    end
    return g;
  endfunction

endpackage

// File: rtl/id_ex_pipe_reg_load_use_detect.sv
// Combinational load-use hazard compare between the load sitting in EX and the
// instruction being decoded in ID. Also used by the branch-in-ID pipeline variant.
module id_ex_pipe_reg_load_use_detect
  import id_ex_pipe_reg_pkg::*;
(
  input  logic       valid_ex,
  input  logic       memread_ex,
  input  logic [4:0] dest_ex,
  input  logic       valid_id,
  input  logic [4:0] rs_id,
  input  logic [4:0] rt_id,
  input  logic       uses_rt_id,
  output logic       hazard
);

  logic load_in_ex_s;
  logic rs_match_s;
  logic rt_match_s;

  // $0 is never a real producer, so a load into it cannot create a dependence
  assign load_in_ex_s = valid_ex & memread_ex & (dest_ex != REG_ZERO);
  assign rs_match_s   = (dest_ex == rs_id);
  assign rt_match_s   = uses_rt_id & (dest_ex == rt_id);
  assign hazard       = load_in_ex_s & valid_id & (rs_match_s | rt_match_s);

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use bubble insertion, flush and hold.
// Optional performance counters are enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_pipe_reg
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int DW   = 32,
  parameter int AOPW = 4
`ifdef ID_EX_PERF_CNT_EN
  ,
  parameter int CNTW = 32
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_id,
  input  logic [4:0]      rs_id,
  input  logic [4:0]      rt_id,
  input  logic [4:0]      rd_id,
  input  logic            uses_rt_id,
  input  logic            regdst_id,
  input  logic            regwrite_id,
  input  logic            memread_id,
  input  logic            memwrite_id,
  input  logic            memtoreg_id,
  input  logic            alusrc_id,
  input  logic [AOPW-1:0] aluop_id,
  input  logic [DW-1:0]   rdata1_id,
  input  logic [DW-1:0]   rdata2_id,
  input  logic [DW-1:0]   imm_id,
  input  logic [DW-1:0]   pc4_id,
  input  logic            flush,
  input  logic            hold,
  output logic            stall_o,
  output logic            valid_ex,
  output logic [4:0]      rs_ex,
  output logic [4:0]      rt_ex,
  output logic [4:0]      dest_ex,
  output logic            regwrite_ex,
  output logic            memread_ex,
  output logic            memwrite_ex,
  output logic            memtoreg_ex,
  output logic            alusrc_ex,
  output logic [AOPW-1:0] aluop_ex,
  output logic [DW-1:0]   rdata1_ex,
  output logic [DW-1:0]   rdata2_ex,
  output logic [DW-1:0]   imm_ex,
  output logic [DW-1:0]   pc4_ex
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [CNTW-1:0] bubble_cnt,
  output logic [CNTW-1:0] flush_cnt,
  output logic [CNTW-1:0] hold_cnt
`endif
);

  logic            hazard_s;
  pipe_act_e       act_s;
  ctrl_t           ctrl_id_s;
  ctrl_t           ctrl_r;

  logic            valid_r;
  logic [4:0]      rs_r;
  logic [4:0]      rt_r;
  logic [4:0]      dest_r;
  logic [AOPW-1:0] aluop_r;
  logic [DW-1:0]   rdata1_r;
  logic [DW-1:0]   rdata2_r;
  logic [DW-1:0]   imm_r;
  logic [DW-1:0]   pc4_r;

  logic            nxt_valid_s;
  ctrl_t           nxt_ctrl_s;
  logic [4:0]      nxt_rs_s;
  logic [4:0]      nxt_rt_s;
  logic [4:0]      nxt_dest_s;
  logic [AOPW-1:0] nxt_aluop_s;
  logic [DW-1:0]   nxt_rdata1_s;
  logic [DW-1:0]   nxt_rdata2_s;
  logic [DW-1:0]   nxt_imm_s;
  logic [DW-1:0]   nxt_pc4_s;

  id_ex_pipe_reg_load_use_detect u_load_use_detect (
    .valid_ex   (valid_r),
    .memread_ex (ctrl_r.memread),
    .dest_ex    (dest_r),
    .valid_id   (valid_id),
    .rs_id      (rs_id),
    .rt_id      (rt_id),
    .uses_rt_id (uses_rt_id),
    .hazard     (hazard_s)
  );

  assign ctrl_id_s = '{regwrite: regwrite_id, memread: memread_id, memwrite: memwrite_id,
                       memtoreg: memtoreg_id, alusrc: alusrc_id};

  // A flushed dependent is squashed anyway, so flush suppresses the load-use stall
  assign stall_o = rst & (hold | (hazard_s & ~flush));

  // Select this cycle's action by priority: flush, hold, load-use bubble, load
  always_comb begin
    act_s = ACT_LOAD;
    if (flush) begin
      act_s = ACT_FLUSH;
    end else if (hold) begin
      act_s = ACT_HOLD;
    end else if (hazard_s) begin
      act_s = ACT_BUBBLE;
    end else begin
      act_s = ACT_LOAD;
    end
  end

  // Next register contents; bubbles clear every field, not just the controls
  always_comb begin
    nxt_valid_s  = 1'b0;
    nxt_ctrl_s   = CTRL_BUBBLE;
    nxt_rs_s     = REG_ZERO;
    nxt_rt_s     = REG_ZERO;
    nxt_dest_s   = REG_ZERO;
    nxt_aluop_s  = {AOPW{1'b0}};
    nxt_rdata1_s = {DW{1'b0}};
    nxt_rdata2_s = {DW{1'b0}};
    nxt_imm_s    = {DW{1'b0}};
    nxt_pc4_s    = {DW{1'b0}};
    case (act_s)
      ACT_LOAD: begin
        nxt_valid_s  = valid_id;
        nxt_ctrl_s   = gate_ctrl(ctrl_id_s, valid_id);
        nxt_rs_s     = rs_id;
        nxt_rt_s     = rt_id;
        nxt_dest_s   = regdst_id ? rd_id : rt_id;
        nxt_aluop_s  = aluop_id;
        nxt_rdata1_s = rdata1_id;
        nxt_rdata2_s = rdata2_id;
        nxt_imm_s    = imm_id;
        nxt_pc4_s    = pc4_id;
      end
      ACT_HOLD: begin
        nxt_valid_s  = valid_r;
        nxt_ctrl_s   = ctrl_r;
        nxt_rs_s     = rs_r;
        nxt_rt_s     = rt_r;
        nxt_dest_s   = dest_r;
        nxt_aluop_s  = aluop_r;
        nxt_rdata1_s = rdata1_r;
        nxt_rdata2_s = rdata2_r;
        nxt_imm_s    = imm_r;
        nxt_pc4_s    = pc4_r;
      end
      ACT_BUBBLE, ACT_FLUSH: begin
        nxt_valid_s = 1'b0;
      end
      default: begin
        nxt_valid_s = 1'b0;
      end
    endcase
  end

  // Pipeline flops with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_r  <= 1'b0;
      ctrl_r   <= CTRL_BUBBLE;
      rs_r     <= REG_ZERO;
      rt_r     <= REG_ZERO;
      dest_r   <= REG_ZERO;
      aluop_r  <= {AOPW{1'b0}};
      rdata1_r <= {DW{1'b0}};
      rdata2_r <= {DW{1'b0}};
      imm_r    <= {DW{1'b0}};
      pc4_r    <= {DW{1'b0}};
    end else begin
      valid_r  <= nxt_valid_s;
      ctrl_r   <= nxt_ctrl_s;
      rs_r     <= nxt_rs_s;
      rt_r     <= nxt_rt_s;
      dest_r   <= nxt_dest_s;
      aluop_r  <= nxt_aluop_s;
      rdata1_r <= nxt_rdata1_s;
      rdata2_r <= nxt_rdata2_s;
      imm_r    <= nxt_imm_s;
      pc4_r    <= nxt_pc4_s;
    end
  end

  assign valid_ex    = valid_r;
  assign rs_ex       = rs_r;
  assign rt_ex       = rt_r;
  assign dest_ex     = dest_r;
  assign regwrite_ex = ctrl_r.regwrite;
  assign memread_ex  = ctrl_r.memread;
  assign memwrite_ex = ctrl_r.memwrite;
  assign memtoreg_ex = ctrl_r.memtoreg;
  assign alusrc_ex   = ctrl_r.alusrc;
  assign aluop_ex    = aluop_r;
  assign rdata1_ex   = rdata1_r;
  assign rdata2_ex   = rdata2_r;
  assign imm_ex      = imm_r;
  assign pc4_ex      = pc4_r;

`ifdef ID_EX_PERF_CNT_EN
  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
    logic [CNTW-1:0] r;
    if (&c) begin
      r = c;
    end else begin
      r = c + {{(CNTW-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  // Saturating event counters, one per non-load action
  always_ff @(posedge clk) begin
    if (!rst) begin
      bubble_cnt <= {CNTW{1'b0}};
      flush_cnt  <= {CNTW{1'b0}};
      hold_cnt   <= {CNTW{1'b0}};
    end else begin
      case (act_s)
        ACT_BUBBLE: bubble_cnt <= sat_inc(bubble_cnt);
        ACT_FLUSH:  flush_cnt  <= sat_inc(flush_cnt);
        ACT_HOLD:   hold_cnt   <= sat_inc(hold_cnt);
        default:    bubble_cnt <= bubble_cnt;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed self-checking bench for id_ex_pipe_reg: reset, load-use bubbles,
// $0 exclusion, flush/hold priority and (with ID_EX_PERF_CNT_EN) counters.
module tb_id_ex_pipe_reg;
  import id_ex_pipe_reg_pkg::*;

  localparam int DW   = 32;
  localparam int AOPW = 4;

  logic            clk;
  logic            rst;
  logic            valid_id;
  logic [4:0]      rs_id, rt_id, rd_id;
  logic            uses_rt_id, regdst_id, regwrite_id, memread_id;
  logic            memwrite_id, memtoreg_id, alusrc_id;
  logic [AOPW-1:0] aluop_id;
  logic [DW-1:0]   rdata1_id, rdata2_id, imm_id, pc4_id;
  logic            flush, hold;
  logic            stall_o, valid_ex;
  logic [4:0]      rs_ex, rt_ex, dest_ex;
  logic            regwrite_ex, memread_ex, memwrite_ex, memtoreg_ex, alusrc_ex;
  logic [AOPW-1:0] aluop_ex;
  logic [DW-1:0]   rdata1_ex, rdata2_ex, imm_ex, pc4_ex;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0]     bubble_cnt, flush_cnt, hold_cnt;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  id_ex_pipe_reg #(.DW(DW), .AOPW(AOPW)) dut (
    .clk(clk), .rst(rst), .valid_id(valid_id),
    .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id),
    .uses_rt_id(uses_rt_id), .regdst_id(regdst_id), .regwrite_id(regwrite_id),
    .memread_id(memread_id), .memwrite_id(memwrite_id), .memtoreg_id(memtoreg_id),
    .alusrc_id(alusrc_id), .aluop_id(aluop_id),
    .rdata1_id(rdata1_id), .rdata2_id(rdata2_id), .imm_id(imm_id), .pc4_id(pc4_id),
    .flush(flush), .hold(hold), .stall_o(stall_o), .valid_ex(valid_ex),
    .rs_ex(rs_ex), .rt_ex(rt_ex), .dest_ex(dest_ex),
    .regwrite_ex(regwrite_ex), .memread_ex(memread_ex), .memwrite_ex(memwrite_ex),
    .memtoreg_ex(memtoreg_ex), .alusrc_ex(alusrc_ex), .aluop_ex(aluop_ex),
    .rdata1_ex(rdata1_ex), .rdata2_ex(rdata2_ex), .imm_ex(imm_ex), .pc4_ex(pc4_ex)
`ifdef ID_EX_PERF_CNT_EN
    , .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt), .hold_cnt(hold_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [31:0] s);
    rdata1_id = s;
    rdata2_id = ~s;
    imm_id    = s ^ 32'h00FF_00FF;
    pc4_id    = s + 32'd4;
  endtask

  task automatic set_ctrl(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic urt, input logic rdst,
                          input logic rw, input logic mr, input logic mw,
                          input logic m2r, input logic asrc);
    valid_id = v; rs_id = rs; rt_id = rt; rd_id = rd; uses_rt_id = urt;
    regdst_id = rdst; regwrite_id = rw; memread_id = mr; memwrite_id = mw;
    memtoreg_id = m2r; alusrc_id = asrc; aluop_id = ALUOP_ADD;
  endtask

  // lw $rt, imm($rs)
  task automatic set_lw(input logic [4:0] rt, input logic [4:0] rs, input logic [31:0] s);
    set_ctrl(1'b1, rs, rt, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    set_data(s);
  endtask

  // add $rd, $rs, $rt
  task automatic set_add(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [31:0] s);
    set_ctrl(1'b1, rs, rt, rd, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    set_data(s);
  endtask

  // sw $rt, imm($rs)
  task automatic set_sw(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                        input logic [31:0] s);
    set_ctrl(1'b1, rs, rt, 5'd0, urt, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    set_data(s);
  endtask

  task automatic set_nop();
    set_ctrl(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_data(32'd0);
  endtask

  initial begin
    // Reset with every ID input driven high
    rst = 1'b0; flush = 1'b1; hold = 1'b1;
    set_ctrl(1'b1, 5'h1F, 5'h1F, 5'h1F, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    aluop_id = 4'hF;
    set_data(32'hFFFF_FFFF);
    rdata2_id = 32'hFFFF_FFFF; imm_id = 32'hFFFF_FFFF; pc4_id = 32'hFFFF_FFFF;
    tick(); tick();
    check("rst_valid", valid_ex, 1'b0);
    check("rst_ctrl", {regwrite_ex, memread_ex, memwrite_ex, memtoreg_ex, alusrc_ex}, 5'd0);
    check("rst_regs", {rs_ex, rt_ex, dest_ex, aluop_ex}, 19'd0);
    check("rst_data", {rdata1_ex, rdata2_ex} | {imm_ex, pc4_ex}, 64'd0);
    check("rst_stall", stall_o, 1'b0);

    rst = 1'b1; flush = 1'b0; hold = 1'b0;
    set_nop();
    tick();

    // Load-use on rs: lw $8 then add $9,$8,$10
    set_lw(5'd8, 5'd9, 32'h0000_00A0);
    #1 check("lw_nostall", stall_o, 1'b0);
    tick();
    check("lw_ex", {valid_ex, memread_ex, dest_ex}, {1'b1, 1'b1, 5'd8});
    check("lw_data", {rdata1_ex, imm_ex}, {32'h0000_00A0, 32'h00FF_005F});
    set_add(5'd9, 5'd8, 5'd10, 32'h0000_00B0);
    #1 check("rs_stall", stall_o, 1'b1);
    tick();
    check("rs_bubble", {valid_ex, regwrite_ex, memread_ex}, 3'b000);
    check("rs_stall_clr", stall_o, 1'b0);
    tick();
    check("add_ex", {valid_ex, rs_ex, rt_ex, dest_ex, regwrite_ex}, {1'b1, 5'd8, 5'd10, 5'd9, 1'b1});
    check("add_data", {rdata2_ex, pc4_ex}, {32'hFFFF_FF4F, 32'h0000_00B4});

    // Load-use through rt of a store, then the same store not reading rt
    set_lw(5'd8, 5'd9, 32'h0000_00C0);
    #1 check("lw2_nostall", stall_o, 1'b0);
    tick();
    set_sw(5'd9, 5'd8, 1'b1, 32'h0000_00D0);
    #1 check("rt_stall", stall_o, 1'b1);
    tick();
    check("rt_bubble", {valid_ex, memwrite_ex}, 2'b00);
    tick();
    check("sw_ex", {valid_ex, memwrite_ex, regwrite_ex, rt_ex}, {1'b1, 1'b1, 1'b0, 5'd8});
    set_lw(5'd8, 5'd9, 32'h0000_00E0);
    tick();
    set_sw(5'd9, 5'd8, 1'b0, 32'h0000_00F0);
    #1 check("nort_nostall", stall_o, 1'b0);
    tick();
    check("sw2_ex", {valid_ex, memwrite_ex, rdata1_ex}, {1'b1, 1'b1, 32'h0000_00F0});

    // Load into $0 never stalls a reader of $0
    set_lw(5'd0, 5'd9, 32'h0000_0100);
    tick();
    check("lw0_ex", {valid_ex, memread_ex, dest_ex}, {1'b1, 1'b1, 5'd0});
    set_add(5'd5, 5'd0, 5'd0, 32'h0000_0110);
    #1 check("r0_nostall", stall_o, 1'b0);
    tick();
    check("r0_pass", {valid_ex, rs_ex, dest_ex}, {1'b1, 5'd0, 5'd5});

    // Invalid ID slot loads a bubble even with controls asserted
    set_add(5'd7, 5'd1, 5'd2, 32'h0000_0120);
    valid_id = 1'b0;
    tick();
    check("inv_bubble", {valid_ex, regwrite_ex}, 2'b00);

    // Hazard and flush in the same cycle: flush wins, no stall
    set_lw(5'd8, 5'd9, 32'h0000_0130);
    tick();
    set_add(5'd9, 5'd8, 5'd10, 32'h0000_0140);
    flush = 1'b1;
    #1 check("flush_nostall", stall_o, 1'b0);
    tick();
    check("flush_bubble", {valid_ex, regwrite_ex, rs_ex, rdata1_ex}, {1'b0, 1'b0, 5'd0, 32'd0});
    flush = 1'b0;

    // Hold freezes a load in EX for three cycles
    set_lw(5'd8, 5'd9, 32'h0000_0150);
    tick();
    set_add(5'd9, 5'd8, 5'd10, 32'h0000_0160);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("hold_stall", stall_o, 1'b1);
      tick();
      check("hold_keep", {valid_ex, memread_ex, dest_ex, rdata1_ex}, {1'b1, 1'b1, 5'd8, 32'h0000_0150});
    end
    hold = 1'b0;
    #1 check("post_hold_stall", stall_o, 1'b1);
    tick();
    check("post_hold_bubble", valid_ex, 1'b0);
    tick();
    check("post_hold_add", {valid_ex, dest_ex, rdata1_ex}, {1'b1, 5'd9, 32'h0000_0160});

    // Flush outranks hold
    set_lw(5'd3, 5'd4, 32'h0000_0170);
    flush = 1'b1; hold = 1'b1;
    tick();
    check("flush_over_hold", {valid_ex, memread_ex}, 2'b00);
    flush = 1'b0; hold = 1'b0;

`ifdef ID_EX_PERF_CNT_EN
    rst = 1'b0;
    tick();
    check("cnt_rst", {bubble_cnt, flush_cnt} | {32'd0, hold_cnt}, 64'd0);
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      set_lw(5'd8, 5'd9, 32'h0000_0200);
      tick();
      set_add(5'd9, 5'd8, 5'd10, 32'h0000_0210);
      tick();
      tick();
    end
    set_nop();
    flush = 1'b1;
    tick();
    flush = 1'b0; hold = 1'b1;
    tick(); tick(); tick();
    hold = 1'b0;
    check("bubble_cnt", bubble_cnt, 32'd2);
    check("flush_cnt", flush_cnt, 32'd1);
    check("hold_cnt", hold_cnt, 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
